char_buf_ctrl: RTL and testbench

Character-buffer controller for the text overlay. It owns a 256-entry by 7-bit character-code RAM that the rectangle text renderer reads through its 8-bit `char_xy` address (`{row[3:0], col[3:0]}`). Two game-logic requesters write into the RAM through a round-robin req/ack handshake. The block also runs a clear sequencer on reset and on demand. It sits between game-state logic (score and status updaters) and the char-pixel lookup path of the text draw stage.

---
 rtl/char_buf_ctrl.sv | 167 ++++++++++++++++
 tb/tb_char_buf_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/char_buf_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | char_buf_ctrl : 256x7 character-code RAM with round-robin writers, clear   |
// |                 sequencer and registered read port for the text overlay.    |
// | Option macro  : CHAR_BUF_VBLANK_WRITE_EN (writes only during vblnk_in)      |
// | Revision      : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module char_buf_ctrl #(
  parameter logic [6:0] CLEAR_CODE = 7'h20
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vblnk_in,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  input  logic       req0,
  input  logic [7:0] addr0,
  input  logic [6:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] addr1,
  input  logic [6:0] data1,
  output logic       ack1,
  input  logic       clear_req,
  output logic       busy
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  localparam logic [7:0] c_LAST_ADDR = 8'hFF;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cptr;
  logic [7:0] w_cptr_nxt;
  logic       r_last;
  logic       w_last_nxt;
  logic       r_ack0;
  logic       w_ack0_nxt;
  logic       r_ack1;
  logic       w_ack1_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic       w_en;
  logic       w_elig0;
  logic       w_elig1;
  logic       w_we;
  logic [7:0] w_waddr;
  logic [6:0] w_wdata;
  logic [6:0] r_char_code;
  logic [6:0] r_mem [256];

`ifdef CHAR_BUF_VBLANK_WRITE_EN
  // Writes are confined to blanking so the visible frame never tears.
  assign w_en = vblnk_in;
`else
  logic w_vblnk_unused;
  assign w_vblnk_unused = vblnk_in;
  assign w_en           = 1'b1;
`endif

  // A port whose ack is high this cycle is mid-handshake and must not be re-granted.
  assign w_elig0 = req0 && !r_ack0;
  assign w_elig1 = req1 && !r_ack1;

  always_comb begin
    w_state_nxt = r_state;
    w_cptr_nxt  = r_cptr;
    w_last_nxt  = r_last;
    w_ack0_nxt  = 1'b0;
    w_ack1_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    w_we        = 1'b0;
    w_waddr     = r_cptr;
    w_wdata     = CLEAR_CODE;

    case (r_state)
      ST_CLEAR: begin
        w_busy_nxt = 1'b1;
        if (clear_req) begin
          w_cptr_nxt = 8'h00;
        end else if (w_en) begin
          w_we       = 1'b1;
          w_cptr_nxt = r_cptr + 8'h01;
          if (r_cptr == c_LAST_ADDR) begin
            w_state_nxt = ST_SERVE;
            w_busy_nxt  = 1'b0;
          end
        end
      end

      ST_SERVE: begin
        w_busy_nxt = 1'b0;
        if (clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_cptr_nxt  = 8'h00;
          w_busy_nxt  = 1'b1;
        end else if (w_en) begin
          // r_last == 1 means port 1 was granted last, so port 0 wins a tie.
          if (w_elig0 && (!w_elig1 || r_last)) begin
            w_we       = 1'b1;
            w_waddr    = addr0;
            w_wdata    = data0;
            w_ack0_nxt = 1'b1;
            w_last_nxt = 1'b0;
          end else if (w_elig1) begin
            w_we       = 1'b1;
            w_waddr    = addr1;
            w_wdata    = data1;
            w_ack1_nxt = 1'b1;
            w_last_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_CLEAR;
        w_cptr_nxt  = 8'h00;
        w_busy_nxt  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cptr  <= 8'h00;
      r_last  <= 1'b1;
      r_ack0  <= 1'b0;
      r_ack1  <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cptr  <= w_cptr_nxt;
      r_last  <= w_last_nxt;
      r_ack0  <= w_ack0_nxt;
      r_ack1  <= w_ack1_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Single write port; no reset so the array maps onto block RAM.
  always_ff @(posedge pclk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Read-before-write: a same-address read in the commit cycle returns old data.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_char_code <= 7'h00;
    end else begin
      r_char_code <= r_mem[char_xy];
    end
  end

  assign char_code = r_char_code;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_char_buf_ctrl.sv
`default_nettype none
// Directed self-checking bench for char_buf_ctrl: clear, writes, arbitration,
// read-during-write, clear restart and blanking-gated writes.
module tb_char_buf_ctrl;

  logic       pclk = 1'b0;
  logic       rst;
  logic       vblnk_in;
  logic [7:0] char_xy;
  logic [6:0] char_code;
  logic       req0, req1;
  logic [7:0] addr0, addr1;
  logic [6:0] data0, data1;
  logic       ack0, ack1;
  logic       clear_req;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  char_buf_ctrl #(.CLEAR_CODE(7'h20)) dut (
    .pclk      (pclk),
    .rst       (rst),
    .vblnk_in  (vblnk_in),
    .char_xy   (char_xy),
    .char_code (char_code),
    .req0      (req0),
    .addr0     (addr0),
    .data0     (data0),
    .ack0      (ack0),
    .req1      (req1),
    .addr1     (addr1),
    .data1     (data1),
    .ack1      (ack1),
    .clear_req (clear_req),
    .busy      (busy)
  );

  always #5 pclk = ~pclk;

  // Advance one active edge and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [6:0] exp);
    char_xy = a;
    tick();
    check(tag, {1'b0, char_code}, {1'b0, exp});
  endtask

  initial begin
    rst = 1'b1; vblnk_in = 1'b1; char_xy = 8'h00; clear_req = 1'b0;
    req0 = 1'b0; addr0 = 8'h00; data0 = 7'h00;
    req1 = 1'b0; addr1 = 8'h00; data1 = 7'h00;
    repeat (3) tick();
    check("rst_ack0", {7'b0, ack0}, 8'h00);
    check("rst_ack1", {7'b0, ack1}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h01);
    check("rst_code", {1'b0, char_code}, 8'h00);

    // Clear after reset: edges 1..256 write addresses 0..255.
    rst = 1'b0;
    repeat (255) tick();
    check("clr_busy_255", {7'b0, busy}, 8'h01);
    tick();
    check("clr_busy_fall", {7'b0, busy}, 8'h00);
    read_chk("clr_rd_00", 8'h00, 7'h20);
    read_chk("clr_rd_80", 8'h80, 7'h20);
    read_chk("clr_rd_ff", 8'hFF, 7'h20);

    // Contention: port 0 wins the first tie, then strict alternation.
    req0 = 1'b1; addr0 = 8'h50; data0 = 7'h01;
    req1 = 1'b1; addr1 = 8'h60; data1 = 7'h02;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("cont_ack0_%0d", i), {7'b0, ack0}, (i % 2 == 0) ? 8'h01 : 8'h00);
      check($sformatf("cont_ack1_%0d", i), {7'b0, ack1}, (i % 2 == 0) ? 8'h00 : 8'h01);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    read_chk("cont_rd_50", 8'h50, 7'h01);
    read_chk("cont_rd_60", 8'h60, 7'h02);

    // Single write from port 0.
    req0 = 1'b1; addr0 = 8'h35; data0 = 7'h41;
    tick();
    check("wr_ack0_hi", {7'b0, ack0}, 8'h01);
    req0 = 1'b0;
    tick();
    check("wr_ack0_lo", {7'b0, ack0}, 8'h00);
    read_chk("wr_rd_35", 8'h35, 7'h41);

    // Read-during-write to 8'h10: old data on the commit edge, new data next.
    req0 = 1'b1; addr0 = 8'h10; data0 = 7'h55; char_xy = 8'h10;
    tick();
    check("rdw_ack0", {7'b0, ack0}, 8'h01);
    check("rdw_old", {1'b0, char_code}, 8'h20);
    req0 = 1'b0;
    tick();
    check("rdw_new", {1'b0, char_code}, 8'h55);

    // Clear on demand, with a same-cycle request that must wait, then a restart at cptr=100.
    clear_req = 1'b1;
    req1 = 1'b1; addr1 = 8'h70; data1 = 7'h33;
    tick();
    clear_req = 1'b0;
    check("cr_busy_rise", {7'b0, busy}, 8'h01);
    check("cr_no_ack1", {7'b0, ack1}, 8'h00);
    for (int i = 0; i < 100; i++) begin
      tick();
      check("cr_pre_ack1", {7'b0, ack1}, 8'h00);
    end
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("cr_restart_busy", {7'b0, busy}, 8'h01);
    for (int i = 0; i < 255; i++) begin
      tick();
      check("cr_busy_hold", {7'b0, busy}, 8'h01);
      check("cr_busy_ack1", {7'b0, ack1}, 8'h00);
    end
    tick();
    check("cr_busy_fall", {7'b0, busy}, 8'h00);
    check("cr_fall_ack1", {7'b0, ack1}, 8'h00);
    tick();
    check("cr_ack1_after", {7'b0, ack1}, 8'h01);
    req1 = 1'b0;
    tick();
    read_chk("cr_rd_70", 8'h70, 7'h33);
    read_chk("cr_rd_35", 8'h35, 7'h20);
    read_chk("cr_rd_50", 8'h50, 7'h20);

`ifdef CHAR_BUF_VBLANK_WRITE_EN
    // Requests wait for blanking; grant follows the first blanking cycle.
    vblnk_in = 1'b0;
    req0 = 1'b1; addr0 = 8'h22; data0 = 7'h66;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("vb_hold_ack0", {7'b0, ack0}, 8'h00);
    end
    vblnk_in = 1'b1;
    tick();
    check("vb_ack0", {7'b0, ack0}, 8'h01);
    req0 = 1'b0;
    tick();
    read_chk("vb_rd_22", 8'h22, 7'h66);
`else
    // Blanking is ignored: a request outside blanking is granted immediately.
    vblnk_in = 1'b0;
    req0 = 1'b1; addr0 = 8'h22; data0 = 7'h66;
    tick();
    check("nvb_ack0", {7'b0, ack0}, 8'h01);
    req0 = 1'b0;
    tick();
    read_chk("nvb_rd_22", 8'h22, 7'h66);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
